// File: rtl/de_multi_channel_accumulator.sv
// de_multi_channel_accumulator: N_CH switch-driven accumulators committed by a debounced push-button,
// with the selected channel shown on active-low HEX digits and sticky per-channel overflow flags.
module de_multi_channel_accumulator #(
    parameter int W               = 8,
    parameter int N_CH            = 4,
    parameter int HEX_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    btn_n,
    input  logic [W-1:0]            operand,
    input  logic [1:0]              op,
    input  logic [$clog2(N_CH)-1:0] ch_sel,
    output logic [7*HEX_DIGITS-1:0] hex_out,
    output logic [N_CH-1:0]         ovf,
    output logic [7:0]              commit_cnt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [W-1:0]            acc_q [N_CH];
    logic [W-1:0]            acc_d [N_CH];
    logic [N_CH-1:0]         ovf_q, ovf_d;
    logic [7:0]              commit_cnt_q, commit_cnt_d;
    logic [7*HEX_DIGITS-1:0] hex_q, hex_d;
    logic [4*HEX_DIGITS-1:0] disp;
    logic [W:0]              sum;
    logic                    synced, last, commit;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign sync_d = {sync_q[0], btn_n};
    assign synced = sync_q[1];
    assign last   = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    // The wait-state counter runs only while the new level holds; any opposite sample aborts the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        commit  = 1'b0;
        case (state_q)
            RELEASED:     state_d = synced ? RELEASED : PRESS_WAIT;
            PRESS_WAIT: begin
                if (synced) state_d = RELEASED;
                else if (last) begin
                    state_d = PRESSED;
                    commit  = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            PRESSED:      state_d = synced ? RELEASE_WAIT : PRESSED;
            RELEASE_WAIT: begin
                if (!synced) state_d = PRESSED;
                else if (last) state_d = RELEASED;
                else cnt_d = cnt_q + 1'b1;
            end
            default:      state_d = RELEASED;
        endcase
    end

    // Bit W of the widened add is the carry; of the widened subtract it is the borrow.
    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        commit_cnt_d = commit_cnt_q;
        sum          = op[1] ? ({1'b0, acc_q[ch_sel]} - {1'b0, operand})
                             : ({1'b0, acc_q[ch_sel]} + {1'b0, operand});
        if (commit) begin
            commit_cnt_d  = commit_cnt_q + 8'd1;
            acc_d[ch_sel] = (op == 2'b00) ? operand : (op == 2'b11) ? '0 : sum[W-1:0];
            ovf_d[ch_sel] = (op[0] ^ op[1]) ? (ovf_q[ch_sel] | sum[W]) : 1'b0;
        end
    end

    always_comb begin
        disp        = '0;
        disp[W-1:0] = acc_q[ch_sel];
        hex_d       = '0;
        for (int i = 0; i < HEX_DIGITS; i++) hex_d[7*i +: 7] = seg7(disp[4*i +: 4]);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_q       <= 2'b11;
            state_q      <= RELEASED;
            cnt_q        <= '0;
            acc_q        <= '{default: '0};
            ovf_q        <= '0;
            commit_cnt_q <= '0;
            hex_q        <= {HEX_DIGITS{7'b1000000}};
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            commit_cnt_q <= commit_cnt_d;
            hex_q        <= hex_d;
        end
    end

    assign hex_out    = hex_q;
    assign ovf        = ovf_q;
    assign commit_cnt = commit_cnt_q;
endmodule

// File: tb/tb_de_multi_channel_accumulator.sv
// tb_de_multi_channel_accumulator: directed bench with a scoreboard of expected post-commit state,
// exercising debounce, the four operations, display selection, reset and counter wrap.
module tb_de_multi_channel_accumulator;
    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_n;
    logic [7:0]  operand;
    logic [1:0]  op;
    logic [1:0]  ch_sel;
    logic [13:0] hex_out;
    logic [3:0]  ovf;
    logic [7:0]  commit_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] hex;
        logic [3:0]  ovf;
        logic [7:0]  cnt;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_acc [4];
    logic [3:0] m_ovf;
    logic [7:0] m_cnt;

    de_multi_channel_accumulator #(
        .W(8), .N_CH(4), .HEX_DIGITS(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .btn_n(btn_n), .operand(operand), .op(op),
        .ch_sel(ch_sel), .hex_out(hex_out), .ovf(ovf), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
            4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
            4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
            4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
        endcase
    endfunction

    function automatic logic [13:0] exp_hex(input logic [7:0] a);
        exp_hex = {seg(a[7:4]), seg(a[3:0])};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [7:0] v, input logic [1:0] k);
        logic [8:0] s;
        case (o)
            2'b00: begin m_acc[k] = v; m_ovf[k] = 1'b0; end
            2'b01: begin
                s = {1'b0, m_acc[k]} + {1'b0, v};
                m_acc[k] = s[7:0];
                if (s[8]) m_ovf[k] = 1'b1;
            end
            2'b10: begin
                if (m_acc[k] < v) m_ovf[k] = 1'b1;
                m_acc[k] = m_acc[k] - v;
            end
            default: begin m_acc[k] = 8'h00; m_ovf[k] = 1'b0; end
        endcase
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic press(input logic [1:0] o, input logic [7:0] v, input logic [1:0] k,
                         input bit bounce, input int hold);
        exp_t e;
        int n;
        logic [7:0] c0;
        model(o, v, k);
        e.hex = exp_hex(m_acc[k]);
        e.ovf = m_ovf;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
        op = o; operand = v; ch_sel = k;
        if (bounce) begin
            btn_n = 1'b0; @(negedge clk);
            btn_n = 1'b1; @(negedge clk);
        end
        btn_n = 1'b0;
        c0 = commit_cnt;
        n = 0;
        while (commit_cnt === c0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd7);
        repeat (hold) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        e = sb.pop_front();
        check("sb_hex", 32'(hex_out), 32'(e.hex));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
        check("sb_cnt", 32'(commit_cnt), 32'(e.cnt));
    endtask

    initial begin
        resetn = 1'b0; btn_n = 1'b1; operand = 8'h00; op = 2'b00; ch_sel = 2'd0;
        m_acc = '{default: 8'h00}; m_ovf = 4'h0; m_cnt = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hex", 32'(hex_out), 32'(14'b1000000_1000000));
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_cnt", 32'(commit_cnt), 32'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Bounced press, then held for 100 cycles: one commit only.
        press(2'b00, 8'hF0, 2'd1, 1'b1, 100);
        press(2'b01, 8'h20, 2'd1, 1'b0, 2);
        check("ch1_hex10", 32'(hex_out), 32'(14'b1111001_1000000));
        check("ch1_ovf", 32'(ovf[1]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) continue;
            @(negedge clk);
            ch_sel = 2'(i);
            @(negedge clk);
            check("other_ch_zero", 32'(hex_out), 32'(exp_hex(8'h00)));
        end

        press(2'b10, 8'h01, 2'd2, 1'b0, 2);
        check("ch2_ff", 32'(hex_out), 32'(exp_hex(8'hFF)));
        press(2'b11, 8'h55, 2'd2, 1'b0, 2);
        check("ch2_clr_ovf", 32'(ovf[2]), 32'h0);

        press(2'b00, 8'hA5, 2'd3, 1'b0, 2);
        press(2'b00, 8'h3C, 2'd0, 1'b0, 2);
        press(2'b10, 8'h0C, 2'd0, 1'b0, 2);

        // Display follows ch_sel one clock later, with no commit.
        @(negedge clk);
        ch_sel = 2'd3;
        #1;
        check("sel_before_edge", 32'(hex_out), 32'(exp_hex(8'h30)));
        @(negedge clk);
        check("sel_after_edge", 32'(hex_out), 32'(exp_hex(8'hA5)));
        check("sel_cnt_same", 32'(commit_cnt), 32'(m_cnt));

        // Reset while the debouncer is mid-way through a press.
        @(negedge clk);
        ch_sel = 2'd0; op = 2'b01; operand = 8'h01; btn_n = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_hex", 32'(hex_out), 32'(14'b1000000_1000000));
        check("mid_rst_ovf", 32'(ovf), 32'h0);
        check("mid_rst_cnt", 32'(commit_cnt), 32'h0);
        btn_n = 1'b1;
        m_acc = '{default: 8'h00}; m_ovf = 4'h0; m_cnt = 8'h00;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_cnt", 32'(commit_cnt), 32'h0);
        ch_sel = 2'd3;
        repeat (2) @(negedge clk);
        check("post_rst_ch3", 32'(hex_out), 32'(exp_hex(8'h00)));

        // 256 commits wrap commit_cnt (and ch0) back to zero.
        for (int i = 0; i < 256; i++) press(2'b01, 8'h01, 2'd0, 1'b0, 1);
        check("wrap_cnt", 32'(commit_cnt), 32'h0);
        check("wrap_ovf", 32'(ovf), 32'h1);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
